game_sequencer: RTL

//  Top-level play controller for the falling-note engine. Owns the note engine's reset and start lines.

---
 rtl/game_sequencer_pkg.sv | 31 +++
 rtl/game_sequencer_rise_detect.sv | 19 +
 rtl/game_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types and defaults for the falling-note game controller.
// Also consumed by the display/HUD blocks.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int SCORE_W = 16;
    localparam int SPEED_W = 20;
    localparam int COMBO_W = 8;
    localparam int MISS_W  = 4;

    localparam logic [SPEED_W-1:0] SPEED_INIT_DEF = 20'd200000;
    localparam logic [SPEED_W-1:0] SPEED_MIN_DEF  = 20'd50000;
    localparam logic [SPEED_W-1:0] SPEED_STEP_DEF = 20'd10000;

    function automatic logic [SCORE_W-1:0] score_add(
        input logic [SCORE_W-1:0] s,
        input logic [1:0]         inc
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {{(SCORE_W-1){1'b0}}, inc};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// Registered rising-edge detector for the note engine's level flags.
// Samples every cycle so a flag already high produces no later edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/game_sequencer.sv
// Play controller: game flow FSM, countdown, speed ramp and scoring.
// Drives the note engine's reset/run lines from the next state.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int                 COUNT_W          = 28,
    parameter int                 COUNTDOWN_CYCLES = 150_000_000,
    parameter logic [SPEED_W-1:0] SPEED_INIT       = SPEED_INIT_DEF,
    parameter logic [SPEED_W-1:0] SPEED_MIN        = SPEED_MIN_DEF,
    parameter logic [SPEED_W-1:0] SPEED_STEP       = SPEED_STEP_DEF,
    parameter int                 HITS_PER_STEP    = 5,
    parameter int                 MAX_MISSES       = 5,
    parameter int                 COMBO_BONUS      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               nm_hit,
    input  logic               nm_missed,
    input  logic               nm_game_over,
    output logic               nm_rst,
    output logic               nm_start,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [MISS_W-1:0]  misses,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               win
);

    localparam int HC_W = $clog2(HITS_PER_STEP + 1);
    localparam logic [HC_W-1:0]    HC_LAST   = HC_W'(HITS_PER_STEP - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST = MISS_W'(MAX_MISSES - 1);
    localparam logic [COUNT_W-1:0] CD_LOAD   = COUNT_W'(COUNTDOWN_CYCLES - 1);
    localparam logic [COMBO_W:0]   BONUS_AT  = (COMBO_W + 1)'(COMBO_BONUS);
    localparam logic [SPEED_W:0]   RAMP_LIM  = {1'b0, SPEED_MIN} + {1'b0, SPEED_STEP};

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] cd_q, cd_d;
    logic [HC_W-1:0]    hc_q, hc_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               win_q, win_d;
    logic               nm_rst_q, nm_start_q, go_q;
    logic               hit_e, miss_e, loss;

    rise_detect u_hit (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (nm_hit),
        .rise_o (hit_e)
    );

    rise_detect u_miss (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (nm_missed),
        .rise_o (miss_e)
    );

    assign loss = miss_e && (miss_q == MISS_LAST);

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        hc_d    = hc_q;
        speed_d = speed_q;
        score_d = score_q;
        combo_d = combo_q;
        miss_d  = miss_q;
        win_d   = win_q;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_start) begin
                    state_d = ST_COUNTDOWN;
                    cd_d    = CD_LOAD;
                    hc_d    = '0;
                    speed_d = SPEED_INIT;
                    score_d = '0;
                    combo_d = '0;
                    miss_d  = '0;
                    win_d   = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (cd_q == '0) state_d = ST_PLAY;
                else            cd_d    = cd_q - 1'b1;
            end
            ST_PLAY: begin
                if (miss_e) begin
                    combo_d = '0;
                    miss_d  = miss_q + 1'b1;
                    if (loss) begin
                        state_d = ST_DONE;
                        win_d   = 1'b0;
                    end
                end else if (hit_e) begin
                    score_d = score_add(score_q,
                        ({1'b0, combo_q} >= BONUS_AT) ? 2'd2 : 2'd1);
                    if (combo_q != '1) combo_d = combo_q + 1'b1;
                    if (hc_q == HC_LAST) begin
                        hc_d    = '0;
                        speed_d = ({1'b0, speed_q} < RAMP_LIM)
                                ? SPEED_MIN : speed_q - SPEED_STEP;
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
                if (nm_game_over && !loss) begin
                    state_d = ST_DONE;
                    win_d   = 1'b1;
                end
                // Pause only lands when no end-of-game fired this cycle
                if (btn_pause && state_d != ST_DONE) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (btn_start)      state_d = ST_IDLE;
                else if (btn_pause) state_d = ST_PLAY;
            end
            ST_DONE: begin
                if (btn_start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cd_q       <= '0;
            hc_q       <= '0;
            speed_q    <= SPEED_INIT;
            score_q    <= '0;
            combo_q    <= '0;
            miss_q     <= '0;
            win_q      <= 1'b0;
            nm_rst_q   <= 1'b1;
            nm_start_q <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            hc_q       <= hc_d;
            speed_q    <= speed_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            miss_q     <= miss_d;
            win_q      <= win_d;
            nm_rst_q   <= (state_d == ST_IDLE);
            nm_start_q <= (state_d == ST_PLAY);
            go_q       <= (state_d == ST_DONE);
        end
    end

    assign nm_rst    = nm_rst_q;
    assign nm_start  = nm_start_q;
    assign speed     = speed_q;
    assign score     = score_q;
    assign combo     = combo_q;
    assign misses    = miss_q;
    assign state     = state_q;
    assign game_over = go_q;
    assign win       = win_q;

endmodule
